// File: rtl/slink_pkg.sv
// Shared definitions for the S-Link PHY controller: FSM encoding and default timing constants.
package slink_pkg;

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_CLK_START  = 3'd1,
    ST_LANE_RESET = 3'd2,
    ST_LANE_WAIT  = 3'd3,
    ST_ACTIVE     = 3'd4,
    ST_IDLE       = 3'd5,
    ST_SHUTDOWN   = 3'd6,
    ST_ERROR      = 3'd7
  } phy_state_t;

  localparam int unsigned SLINK_RESET_CYCLES   = 8;
  localparam int unsigned SLINK_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/slink_phy_ctrl_timer.sv
// Ready-wait counter: counts cycles while run is high, flags expiry on the limit-th cycle.
module slink_phy_ctrl_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             run,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic             at_limit;

  // count_q is zero on the first waiting cycle, so limit-1 marks the limit-th cycle
  assign at_limit = (count_q >= (limit - WIDTH'(1)));
  assign expired  = run && at_limit;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else if (run && !at_limit) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/slink_io_phy_ctrl.sv
// PHY bring-up / idle / shutdown sequencer for the S-Link IO.
// Optional ready-wait timeout and ERROR state enabled by `define SLINK_PHY_CTRL_TIMEOUT_EN.
module slink_io_phy_ctrl
  import slink_pkg::*;
#(
  parameter int unsigned NUM_TX_LANES   = 4,
  parameter int unsigned NUM_RX_LANES   = 4,
  parameter int unsigned RESET_CYCLES   = SLINK_RESET_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = SLINK_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    idle_req,
  input  logic [NUM_TX_LANES-1:0] tx_lane_mask,
  input  logic [NUM_RX_LANES-1:0] rx_lane_mask,
  output logic                    phy_clk_enable,
  output logic                    phy_clk_idle,
  input  logic                    phy_clk_ready,
  output logic [NUM_TX_LANES-1:0] phy_tx_enable,
  output logic [NUM_TX_LANES-1:0] phy_tx_reset,
  input  logic [NUM_TX_LANES-1:0] phy_tx_ready,
  output logic [NUM_RX_LANES-1:0] phy_rx_enable,
  output logic [NUM_RX_LANES-1:0] phy_rx_reset,
  input  logic [NUM_RX_LANES-1:0] phy_rx_ready,
  output logic                    link_ready,
  output logic                    in_idle,
  output logic                    timeout_err,
  output logic [2:0]              state
);

  if (RESET_CYCLES < 1 || RESET_CYCLES > 255) begin : g_bad_reset_cycles
    $error("RESET_CYCLES must be within 1..255");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_cycles
    $error("TIMEOUT_CYCLES must be within 2..65535");
  end

  phy_state_t state_q, state_d;

  logic [NUM_TX_LANES-1:0] tx_mask_q, tx_mask_d;
  logic [NUM_RX_LANES-1:0] rx_mask_q, rx_mask_d;
  logic [7:0]              rst_cnt_q;
  logic                    rst_done;
  logic                    lanes_ready;
  logic                    wait_expired;
  logic                    enter_clk_start;

  logic                    clk_enable_d, clk_idle_d, link_ready_d, in_idle_d;
  logic [NUM_TX_LANES-1:0] tx_enable_d, tx_reset_d;
  logic [NUM_RX_LANES-1:0] rx_enable_d, rx_reset_d;

  assign rst_done    = (rst_cnt_q == 8'(RESET_CYCLES - 1));
  assign lanes_ready = ((phy_tx_ready & tx_mask_q) == tx_mask_q) &&
                       ((phy_rx_ready & rx_mask_q) == rx_mask_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:        if (enable) state_d = ST_CLK_START;
      ST_CLK_START: begin
        if (!enable)            state_d = ST_SHUTDOWN;
        else if (phy_clk_ready) state_d = ST_LANE_RESET;
        else if (wait_expired)  state_d = ST_ERROR;
      end
      ST_LANE_RESET: begin
        if (!enable)       state_d = ST_SHUTDOWN;
        else if (rst_done) state_d = ST_LANE_WAIT;
      end
      ST_LANE_WAIT: begin
        if (!enable)           state_d = ST_SHUTDOWN;
        else if (lanes_ready)  state_d = ST_ACTIVE;
        else if (wait_expired) state_d = ST_ERROR;
      end
      ST_ACTIVE: begin
        if (!enable)       state_d = ST_SHUTDOWN;
        else if (idle_req) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!enable)        state_d = ST_SHUTDOWN;
        else if (!idle_req) state_d = ST_CLK_START;
      end
      ST_SHUTDOWN:   state_d = ST_OFF;
      ST_ERROR:      if (!enable) state_d = ST_OFF;
      default:       state_d = ST_OFF;
    endcase
  end

  assign enter_clk_start = (state_d == ST_CLK_START) && (state_q != ST_CLK_START);
  assign tx_mask_d = !enter_clk_start      ? tx_mask_q :
                     (tx_lane_mask == '0)  ? NUM_TX_LANES'(1) : tx_lane_mask;
  assign rx_mask_d = !enter_clk_start      ? rx_mask_q :
                     (rx_lane_mask == '0)  ? NUM_RX_LANES'(1) : rx_lane_mask;

  // Outputs are decoded from the state being entered so they register alongside it
  always_comb begin
    clk_enable_d = 1'b0;
    clk_idle_d   = 1'b0;
    link_ready_d = 1'b0;
    in_idle_d    = 1'b0;
    tx_enable_d  = '0;
    tx_reset_d   = '1;
    rx_enable_d  = '0;
    rx_reset_d   = '1;
    case (state_d)
      ST_CLK_START: clk_enable_d = 1'b1;
      ST_LANE_RESET: begin
        clk_enable_d = 1'b1;
        tx_enable_d  = tx_mask_d;
        rx_enable_d  = rx_mask_d;
      end
      ST_LANE_WAIT, ST_ACTIVE: begin
        clk_enable_d = 1'b1;
        link_ready_d = (state_d == ST_ACTIVE);
        tx_enable_d  = tx_mask_d;
        tx_reset_d   = ~tx_mask_d;
        rx_enable_d  = rx_mask_d;
        rx_reset_d   = ~rx_mask_d;
      end
      ST_IDLE: begin
        clk_enable_d = 1'b1;
        clk_idle_d   = 1'b1;
        in_idle_d    = 1'b1;
        tx_reset_d   = ~tx_mask_d;
        rx_reset_d   = ~rx_mask_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_OFF;
      tx_mask_q      <= '0;
      rx_mask_q      <= '0;
      rst_cnt_q      <= '0;
      phy_clk_enable <= 1'b0;
      phy_clk_idle   <= 1'b0;
      phy_tx_enable  <= '0;
      phy_tx_reset   <= '1;
      phy_rx_enable  <= '0;
      phy_rx_reset   <= '1;
      link_ready     <= 1'b0;
      in_idle        <= 1'b0;
    end else begin
      state_q        <= state_d;
      tx_mask_q      <= tx_mask_d;
      rx_mask_q      <= rx_mask_d;
      rst_cnt_q      <= (state_q == ST_LANE_RESET) ? rst_cnt_q + 8'd1 : 8'd0;
      phy_clk_enable <= clk_enable_d;
      phy_clk_idle   <= clk_idle_d;
      phy_tx_enable  <= tx_enable_d;
      phy_tx_reset   <= tx_reset_d;
      phy_rx_enable  <= rx_enable_d;
      phy_rx_reset   <= rx_reset_d;
      link_ready     <= link_ready_d;
      in_idle        <= in_idle_d;
    end
  end

  assign state = state_q;

`ifdef SLINK_PHY_CTRL_TIMEOUT_EN
  logic timer_clear, timer_run;

  // Clearing on every transition covers entry into both waiting states
  assign timer_clear = reset || (state_d != state_q);
  assign timer_run   = (state_q == ST_CLK_START) || (state_q == ST_LANE_WAIT);

  slink_phy_ctrl_timer #(
    .WIDTH (16)
  ) u_timer (
    .clk     (clk),
    .clear   (timer_clear),
    .run     (timer_run),
    .limit   (16'(TIMEOUT_CYCLES)),
    .expired (wait_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) timeout_err <= 1'b0;
    else       timeout_err <= (state_d == ST_ERROR);
  end
`else
  assign wait_expired = 1'b0;
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_slink_io_phy_ctrl.sv
// Directed bench for slink_io_phy_ctrl: mask/ready vector table plus bring-up, idle, collision, reset and timeout sequences.
module tb_slink_io_phy_ctrl;

  logic       clk = 1'b0;
  logic       reset, enable, idle_req, phy_clk_ready;
  logic [3:0] tx_lane_mask, rx_lane_mask, phy_tx_ready, phy_rx_ready;
  logic       phy_clk_enable, phy_clk_idle, link_ready, in_idle, timeout_err;
  logic [3:0] phy_tx_enable, phy_tx_reset, phy_rx_enable, phy_rx_reset;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  slink_io_phy_ctrl #(
    .NUM_TX_LANES   (4),
    .NUM_RX_LANES   (4),
    .RESET_CYCLES   (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .idle_req       (idle_req),
    .tx_lane_mask   (tx_lane_mask),
    .rx_lane_mask   (rx_lane_mask),
    .phy_clk_enable (phy_clk_enable),
    .phy_clk_idle   (phy_clk_idle),
    .phy_clk_ready  (phy_clk_ready),
    .phy_tx_enable  (phy_tx_enable),
    .phy_tx_reset   (phy_tx_reset),
    .phy_tx_ready   (phy_tx_ready),
    .phy_rx_enable  (phy_rx_enable),
    .phy_rx_reset   (phy_rx_reset),
    .phy_rx_ready   (phy_rx_ready),
    .link_ready     (link_ready),
    .in_idle        (in_idle),
    .timeout_err    (timeout_err),
    .state          (state)
  );

  typedef struct {
    logic [3:0] tx_mask, rx_mask, tx_rdy, rx_rdy;
    logic [2:0] exp_state;
    logic       exp_link;
    logic [3:0] exp_tx_en, exp_tx_rst, exp_rx_en, exp_rx_rst;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; idle_req = 1'b0; phy_clk_ready = 1'b0;
    tx_lane_mask = 4'h0; rx_lane_mask = 4'h0; phy_tx_ready = 4'h0; phy_rx_ready = 4'h0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"},   32'(state), 32'd0);
    chk({tag, "_clk_en"},  32'(phy_clk_enable), 32'd0);
    chk({tag, "_clk_idle"},32'(phy_clk_idle), 32'd0);
    chk({tag, "_tx_en"},   32'(phy_tx_enable), 32'h0);
    chk({tag, "_tx_rst"},  32'(phy_tx_reset), 32'hF);
    chk({tag, "_rx_en"},   32'(phy_rx_enable), 32'h0);
    chk({tag, "_rx_rst"},  32'(phy_rx_reset), 32'hF);
    chk({tag, "_link"},    32'(link_ready), 32'd0);
    chk({tag, "_in_idle"}, 32'(in_idle), 32'd0);
    chk({tag, "_terr"},    32'(timeout_err), 32'd0);
  endtask

  initial begin
    int rst_cycles;
    bit reached;

    vecs[0] = '{4'hF, 4'hF, 4'hF, 4'hF, 3'd4, 1'b1, 4'hF, 4'h0, 4'hF, 4'h0};
    vecs[1] = '{4'h3, 4'hF, 4'h3, 4'hF, 3'd4, 1'b1, 4'h3, 4'hC, 4'hF, 4'h0};
    vecs[2] = '{4'h0, 4'hF, 4'h1, 4'hF, 3'd4, 1'b1, 4'h1, 4'hE, 4'hF, 4'h0};
    vecs[3] = '{4'h5, 4'hA, 4'h5, 4'hA, 3'd4, 1'b1, 4'h5, 4'hA, 4'hA, 4'h5};
    vecs[4] = '{4'h8, 4'h1, 4'hF, 4'hF, 3'd4, 1'b1, 4'h8, 4'h7, 4'h1, 4'hE};
    vecs[5] = '{4'hF, 4'h0, 4'hF, 4'h1, 3'd4, 1'b1, 4'hF, 4'h0, 4'h1, 4'hE};
`ifdef SLINK_PHY_CTRL_TIMEOUT_EN
    vecs[6] = '{4'hF, 4'hF, 4'h7, 4'hF, 3'd7, 1'b0, 4'h0, 4'hF, 4'h0, 4'hF};
`else
    vecs[6] = '{4'hF, 4'hF, 4'h7, 4'hF, 3'd3, 1'b0, 4'hF, 4'h0, 4'hF, 4'h0};
`endif

    // Reset state
    do_reset();
    chk_reset_outputs("reset");

    // Vector table: steady-state lane outputs for each mask/ready pattern
    for (int i = 0; i < 7; i++) begin
      do_reset();
      tx_lane_mask = vecs[i].tx_mask; rx_lane_mask = vecs[i].rx_mask;
      phy_tx_ready = vecs[i].tx_rdy;  phy_rx_ready = vecs[i].rx_rdy;
      phy_clk_ready = 1'b1; enable = 1'b1;
      repeat (40) step();
      chk($sformatf("vec%0d_state", i),  32'(state), 32'(vecs[i].exp_state));
      chk($sformatf("vec%0d_link", i),   32'(link_ready), 32'(vecs[i].exp_link));
      chk($sformatf("vec%0d_tx_en", i),  32'(phy_tx_enable), 32'(vecs[i].exp_tx_en));
      chk($sformatf("vec%0d_tx_rst", i), 32'(phy_tx_reset), 32'(vecs[i].exp_tx_rst));
      chk($sformatf("vec%0d_rx_en", i),  32'(phy_rx_enable), 32'(vecs[i].exp_rx_en));
      chk($sformatf("vec%0d_rx_rst", i), 32'(phy_rx_reset), 32'(vecs[i].exp_rx_rst));
    end

    // Bring-up with delayed clock and lane readiness
    do_reset();
    tx_lane_mask = 4'hF; rx_lane_mask = 4'hF; enable = 1'b1;
    rst_cycles = 0; reached = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 3) begin phy_tx_ready = 4'hF; phy_rx_ready = 4'hF; end
      if (i == 5) phy_clk_ready = 1'b1;
      step();
      if (i == 0) begin
        chk("bringup_clk_start", 32'(state), 32'd1);
        chk("bringup_clk_en", 32'(phy_clk_enable), 32'd1);
      end
      if (state == 3'd2 && phy_tx_reset == 4'hF && phy_tx_enable == 4'hF) rst_cycles++;
      if (state == 3'd4) begin reached = 1'b1; break; end
    end
    chk("bringup_reached", 32'(reached), 32'd1);
    chk("bringup_link", 32'(link_ready), 32'd1);
    chk("bringup_reset_len", 32'(rst_cycles), 32'd8);

    // Ready drop while active is ignored
    phy_tx_ready = 4'h0; phy_rx_ready = 4'h0;
    repeat (2) step();
    chk("ready_drop_state", 32'(state), 32'd4);
    chk("ready_drop_link", 32'(link_ready), 32'd1);

    // Idle round trip with a new mask picked up on exit
    idle_req = 1'b1;
    step();
    chk("idle_state", 32'(state), 32'd5);
    chk("idle_in_idle", 32'(in_idle), 32'd1);
    chk("idle_clk_idle", 32'(phy_clk_idle), 32'd1);
    chk("idle_clk_en", 32'(phy_clk_enable), 32'd1);
    chk("idle_tx_en", 32'(phy_tx_enable), 32'h0);
    chk("idle_tx_rst", 32'(phy_tx_reset), 32'h0);
    chk("idle_link", 32'(link_ready), 32'd0);
    tx_lane_mask = 4'h3; phy_tx_ready = 4'hF; phy_rx_ready = 4'hF;
    step();
    chk("idle_hold", 32'(state), 32'd5);
    idle_req = 1'b0;
    step();
    chk("idle_exit_state", 32'(state), 32'd1);
    chk("idle_exit_in_idle", 32'(in_idle), 32'd0);
    rst_cycles = 0; reached = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (state == 3'd2 && phy_tx_enable == 4'h3 && phy_tx_reset == 4'hF) rst_cycles++;
      if (state == 3'd4) begin reached = 1'b1; break; end
    end
    chk("rejoin_reached", 32'(reached), 32'd1);
    chk("rejoin_reset_len", 32'(rst_cycles), 32'd8);
    chk("rejoin_link", 32'(link_ready), 32'd1);
    chk("rejoin_tx_en", 32'(phy_tx_enable), 32'h3);
    chk("rejoin_tx_rst", 32'(phy_tx_reset), 32'hC);

    // enable=0 and idle_req=1 together: shutdown wins
    enable = 1'b0; idle_req = 1'b1;
    step();
    chk("coll_state", 32'(state), 32'd6);
    chk("coll_in_idle", 32'(in_idle), 32'd0);
    chk("coll_tx_en", 32'(phy_tx_enable), 32'h0);
    chk("coll_tx_rst", 32'(phy_tx_reset), 32'hF);
    chk("coll_clk_en", 32'(phy_clk_enable), 32'd0);
    chk("coll_link", 32'(link_ready), 32'd0);
    step();
    chk("coll_off", 32'(state), 32'd0);
    chk("coll_off_in_idle", 32'(in_idle), 32'd0);
    idle_req = 1'b0;

    // Reset during the 4th lane-reset cycle
    do_reset();
    tx_lane_mask = 4'hF; rx_lane_mask = 4'hF; phy_clk_ready = 1'b1; enable = 1'b1;
    step();
    step();
    chk("midrst_lane_reset", 32'(state), 32'd2);
    repeat (3) step();
    chk("midrst_still_lane_reset", 32'(state), 32'd2);
    reset = 1'b1;
    step();
    chk_reset_outputs("midrst");
    reset = 1'b0;

`ifdef SLINK_PHY_CTRL_TIMEOUT_EN
    // Clock never ready: ERROR after 16 cycles in CLK_START
    do_reset();
    tx_lane_mask = 4'hF; rx_lane_mask = 4'hF; enable = 1'b1;
    step();
    chk("to_clk_start", 32'(state), 32'd1);
    repeat (15) step();
    chk("to_cycle16", 32'(state), 32'd1);
    chk("to_cycle16_terr", 32'(timeout_err), 32'd0);
    step();
    chk("to_error", 32'(state), 32'd7);
    chk("to_terr", 32'(timeout_err), 32'd1);
    chk("to_clk_en", 32'(phy_clk_enable), 32'd0);
    chk("to_tx_rst", 32'(phy_tx_reset), 32'hF);
    repeat (3) step();
    chk("to_error_hold", 32'(state), 32'd7);
    chk("to_terr_sticky", 32'(timeout_err), 32'd1);
    enable = 1'b0;
    step();
    chk("to_off", 32'(state), 32'd0);
    chk("to_off_terr", 32'(timeout_err), 32'd0);
`else
    // Without the timeout, CLK_START waits indefinitely
    do_reset();
    tx_lane_mask = 4'hF; rx_lane_mask = 4'hF; enable = 1'b1;
    repeat (40) step();
    chk("nto_wait_state", 32'(state), 32'd1);
    chk("nto_terr", 32'(timeout_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
